// File: rtl/fir3_pkg.sv
// ============================================================================
// Module      : fir3_pkg
// Description : Shared widths, counts and FSM state type for the fir3_seq front-end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir3_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int NTAPS      = 9;
  localparam int LANES      = 3;
  localparam int IDX_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fir3_coef_bank.sv
// ============================================================================
// Module      : fir3_coef_bank
// Description : Shadow coefficient registers with a word index; the full set
//               is copied to the active outputs on the ninth accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir3_coef_bank
  import fir3_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  output logic [NTAPS-1:0][DW-1:0]   coef,
  output logic                       apply
);

  logic [IDX_W-1:0]          r_idx;
  logic [DW-1:0]             r_shadow [NTAPS];
  logic [NTAPS-1:0][DW-1:0]  r_coef;

  assign apply = wr_en && (r_idx == IDX_W'(NTAPS - 1));
  assign coef  = r_coef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (wr_en) begin
      r_idx <= apply ? '0 : r_idx + 1'b1;
    end
  end

  // The last word bypasses its shadow slot so the whole set lands on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_shadow[i] <= '0;
        r_coef[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        if (wr_en && (r_idx == IDX_W'(i))) begin
          r_shadow[i] <= wr_data;
        end
        if (apply) begin
          r_coef[i] <= (r_idx == IDX_W'(i)) ? wr_data : r_shadow[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir3_seq.sv
// ============================================================================
// Module      : fir3_seq
// Description : Coefficient loader and 3-lane sample packer feeding the
//               3-parallel FIR. Define FIR3_SEQ_FLUSH_EN to let LAST close a
//               partial frame with zero-filled lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir3_seq
  import fir3_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_ready,
  input  logic [DW-1:0] din,
  input  logic          vin,
  input  logic          last,
  output logic          din_ready,
  output logic [DW-1:0] b0,
  output logic [DW-1:0] b1,
  output logic [DW-1:0] b2,
  output logic [DW-1:0] b3,
  output logic [DW-1:0] b4,
  output logic [DW-1:0] b5,
  output logic [DW-1:0] b6,
  output logic [DW-1:0] b7,
  output logic [DW-1:0] b8,
  output logic [DW-1:0] dout_3k,
  output logic [DW-1:0] dout_3k1,
  output logic [DW-1:0] dout_3k2,
  output logic          vout,
  output logic          busy,
  output logic          coef_ok
);

`ifdef FIR3_SEQ_FLUSH_EN
  localparam logic c_FLUSH_EN = 1'b1;
`else
  localparam logic c_FLUSH_EN = 1'b0;
`endif

  localparam logic [1:0] c_LAST_LANE = 2'(LANES - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_wr_en;
  logic                      w_apply;
  logic [NTAPS-1:0][DW-1:0]  w_coef;
  logic                      w_accept;
  logic                      w_flush;
  logic                      w_run_restart;

  logic                      r_coef_ok;
  logic [1:0]                r_lane;
  logic [DW-1:0]             r_hold0;
  logic [DW-1:0]             r_hold1;
  logic [DW-1:0]             r_dout_3k;
  logic [DW-1:0]             r_dout_3k1;
  logic [DW-1:0]             r_dout_3k2;
  logic                      r_vout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cfg_start) w_state_nxt = LOAD;
      LOAD: begin
        if (cfg_start)    w_state_nxt = LOAD;
        else if (w_apply) w_state_nxt = RUN;
      end
      RUN:     if (cfg_start) w_state_nxt = LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign cfg_ready = (r_state == LOAD);
  assign busy      = (r_state == LOAD);
  assign din_ready = (r_state == RUN);

  // A restart in LOAD discards any word offered in the same cycle.
  assign w_wr_en       = cfg_valid && cfg_ready && !cfg_start;
  assign w_accept      = vin && din_ready;
  assign w_flush       = c_FLUSH_EN && last;
  assign w_run_restart = cfg_start && din_ready;

  fir3_coef_bank #(
    .DW (DW)
  ) u_coef_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cfg_start),
    .wr_en   (w_wr_en),
    .wr_data (cfg_data),
    .coef    (w_coef),
    .apply   (w_apply)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coef_ok <= 1'b0;
    end else if (w_apply) begin
      r_coef_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane     <= 2'd0;
      r_hold0    <= '0;
      r_hold1    <= '0;
      r_dout_3k  <= '0;
      r_dout_3k1 <= '0;
      r_dout_3k2 <= '0;
      r_vout     <= 1'b0;
    end else begin
      r_vout <= 1'b0;
      if (w_accept) begin
        if (r_lane == 2'd0) begin
          r_hold0 <= din;
          if (w_flush) begin
            r_dout_3k  <= din;
            r_dout_3k1 <= '0;
            r_dout_3k2 <= '0;
            r_vout     <= 1'b1;
          end else begin
            r_lane <= 2'd1;
          end
        end else if (r_lane == 2'd1) begin
          r_hold1 <= din;
          if (w_flush) begin
            r_dout_3k  <= r_hold0;
            r_dout_3k1 <= din;
            r_dout_3k2 <= '0;
            r_vout     <= 1'b1;
            r_lane     <= 2'd0;
          end else begin
            r_lane <= c_LAST_LANE;
          end
        end else begin
          r_dout_3k  <= r_hold0;
          r_dout_3k1 <= r_hold1;
          r_dout_3k2 <= din;
          r_vout     <= 1'b1;
          r_lane     <= 2'd0;
        end
      end
      // The same-cycle sample is handled above; only the leftover partial frame is dropped.
      if (w_run_restart) begin
        r_lane <= 2'd0;
      end
    end
  end

  assign coef_ok  = r_coef_ok;
  assign vout     = r_vout;
  assign dout_3k  = r_dout_3k;
  assign dout_3k1 = r_dout_3k1;
  assign dout_3k2 = r_dout_3k2;

  assign b0 = w_coef[0];
  assign b1 = w_coef[1];
  assign b2 = w_coef[2];
  assign b3 = w_coef[3];
  assign b4 = w_coef[4];
  assign b5 = w_coef[5];
  assign b6 = w_coef[6];
  assign b7 = w_coef[7];
  assign b8 = w_coef[8];

endmodule

`default_nettype wire

// File: tb/tb_fir3_seq.sv
// ============================================================================
// Module      : tb_fir3_seq
// Description : Scoreboard bench for fir3_seq with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir3_seq;

`ifdef FIR3_SEQ_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'd0;
  logic [7:0] din = 8'd0;
  logic       vin = 1'b0;
  logic       last = 1'b0;
  logic       cfg_ready, din_ready, vout, busy, coef_ok;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic [7:0] dout_3k, dout_3k1, dout_3k2;

  always #5 clk = ~clk;

  fir3_seq #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .din(din), .vin(vin), .last(last), .din_ready(din_ready),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
    .dout_3k(dout_3k), .dout_3k1(dout_3k1), .dout_3k2(dout_3k2),
    .vout(vout), .busy(busy), .coef_ok(coef_ok)
  );

  wire [71:0] b_all  = {b0, b1, b2, b3, b4, b5, b6, b7, b8};
  wire [23:0] frm_all = {dout_3k, dout_3k1, dout_3k2};

  typedef struct packed {
    logic [23:0] frm;
    logic [71:0] cf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;

  // Reference model: 0 idle, 1 load, 2 run
  int          mode;
  logic [7:0]  words[$];
  logic [7:0]  part[$];
  logic [71:0] act_cf;
  logic        cok_m;
  logic        vout_m;
  logic [23:0] last_frm;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mode = 0;
    words.delete();
    part.delete();
    act_cf = '0;
    cok_m = 1'b0;
    vout_m = 1'b0;
    last_frm = '0;
    sb.delete();
  endfunction

  function automatic void model_step();
    vout_m = 1'b0;
    case (mode)
      0: if (cfg_start) begin mode = 1; words.delete(); end
      1: begin
        if (cfg_start) begin
          words.delete();
        end else if (cfg_valid) begin
          words.push_back(cfg_data);
          if (words.size() == 9) begin
            act_cf = '0;
            foreach (words[i]) act_cf = {act_cf[63:0], words[i]};
            cok_m = 1'b1;
            words.delete();
            mode = 2;
          end
        end
      end
      default: begin
        if (vin) begin
          part.push_back(din);
          if (part.size() == 3 || (FLUSH && last)) begin
            while (part.size() < 3) part.push_back(8'd0);
            last_frm = {part[0], part[1], part[2]};
            vout_m = 1'b1;
            sb.push_back('{frm: last_frm, cf: act_cf});
            part.delete();
          end
        end
        if (cfg_start) begin
          part.delete();
          mode = 1;
        end
      end
    endcase
  endfunction

  // Monitor: per-cycle state checks plus scoreboard pop on each frame strobe.
  always @(negedge clk) begin
    exp_t e;
    chk("cfg_ready", cfg_ready, mode == 1);
    chk("busy", busy, mode == 1);
    chk("din_ready", din_ready, mode == 2);
    chk("coef_ok", coef_ok, cok_m);
    chk("coefs", b_all, act_cf);
    chk("vout", vout, vout_m);
    chk("dout_hold", frm_all, last_frm);
    if (vout) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%0h expected=none at %0t", frm_all, $time);
      end else begin
        e = sb.pop_front();
        chk("frame", frm_all, e.frm);
        chk("frame_coefs", b_all, e.cf);
      end
    end
  end

  task automatic cyc(input logic cs, input logic cv, input logic [7:0] cd,
                     input logic v, input logic [7:0] d, input logic l);
    cfg_start = cs;
    cfg_valid = cv;
    cfg_data  = cd;
    vin       = v;
    din       = d;
    last      = l;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'd0, 0, 8'd0, 0);
  endtask

  task automatic load_set(input logic [7:0] base);
    cyc(1, 0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, base + 8'(i), 0, 8'd0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coef_ok", coef_ok, 0);
    chk("rst_vout", vout, 0);
    chk("rst_coefs", b_all, 0);
    chk("rst_dout", frm_all, 0);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Load 1..9, then pack 10..15 back to back
    load_set(8'd1);
    for (int s = 10; s <= 15; s++) cyc(0, 0, 8'd0, 1, 8'(s), 0);
    idle(3);

    // Reload after a partial frame
    cyc(0, 0, 8'd0, 1, 8'd20, 0);
    cyc(0, 0, 8'd0, 1, 8'd21, 0);
    cyc(1, 0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'($urandom), 0, 8'd0, 0);
    for (int s = 30; s <= 32; s++) cyc(0, 0, 8'd0, 1, 8'(s), 0);
    idle(2);

    // LAST mid-frame
    cyc(0, 0, 8'd0, 1, 8'd40, 0);
    cyc(0, 0, 8'd0, 1, 8'd41, 1);
    idle(3);
    for (int s = 42; s <= 45; s++) cyc(0, 0, 8'd0, 1, 8'(s), 0);
    idle(2);

    // Restart wins over a same-cycle word
    cyc(1, 0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(90 + i), 0, 8'd0, 0);
    cyc(1, 1, 8'd99, 0, 8'd0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'(50 + i), 0, 8'd0, 0);
    for (int s = 60; s <= 65; s++) cyc(0, 0, 8'd0, 1, 8'(s), 0);
    idle(2);

    // Reset mid-load, samples ignored until a fresh load
    cyc(1, 0, 8'd0, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'(70 + i), 0, 8'd0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'd0, 1, 8'd7, 0);
    load_set(8'd100);
    for (int s = 80; s <= 85; s++) cyc(0, 0, 8'd0, 1, 8'(s), 0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0), 8'($urandom),
          ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) == 0));
    end

    idle(4);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
